program_counter: RTL and testbench

//  Instruction-address register of the CPU, directly upstream of the instruction memory and
//  fed by the Mux16 jump-target selection. Holds the current PC, and per clock loads a jump

---
 rtl/program_counter.sv | 87 ++++++++
 tb/tb_program_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter with jump, increment and call/return via a LIFO return-address stack.
// Latency: 1 cycle; PC_STACK_ERR_EN adds a sticky error for stack overflow/underflow
// instead of circular overwrite. Backpressure: none, a command is accepted every cycle.
module program_counter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [WIDTH-1:0]       out,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   inc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   empty,
  output logic                   full,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  // Next slot to write; the top entry sits one below. Wraps, so a full stack
  // points at its oldest entry, which is what circular overwrite replaces.
  logic [PW-1:0]    top_ptr;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] top_val;
  logic             do_call;
  logic             do_ret;
  logic             push;

  assign empty    = (depth == '0);
  assign full     = (depth == FULL_CNT);
  assign ret_addr = out + 1'b1;
  assign top_val  = stack[top_ptr - 1'b1];
  assign do_call  = !load && call;
  assign do_ret   = !load && !call && ret;

`ifdef PC_STACK_ERR_EN
  assign push = do_call && !full;
`else
  assign push = do_call;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      depth   <= '0;
      top_ptr <= '0;
    end else begin
      if (load || do_call) begin
        out <= in;
      end else if (do_ret) begin
        if (!empty) out <= top_val;
      end else if (inc) begin
        out <= ret_addr;
      end

      if (push) begin
        top_ptr <= top_ptr + 1'b1;
        if (!full) depth <= depth + 1'b1;
      end else if (do_ret && !empty) begin
        top_ptr <= top_ptr - 1'b1;
        depth   <= depth - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) stack[top_ptr] <= ret_addr;
  end

`ifdef PC_STACK_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((do_call && full) || (do_ret && empty)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: queue-based reference model compared every cycle,
// directed literal checks, then randomized command streams.
module tb_program_counter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] in;
  logic             load, call, ret, inc;
  logic [3:0]       depth;
  logic             empty, full, err;

  program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .out(out), .in(in),
    .load(load), .call(call), .ret(ret), .inc(inc),
    .depth(depth), .empty(empty), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC value, return addresses as a queue (back = top), error flag.
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_q[$];
  logic             m_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

`ifdef PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [WIDTH-1:0] ra;
    ra = m_out + 1'b1;
    if (reset) begin
      m_out = '0;
      m_q.delete();
      m_err = 1'b0;
    end else if (load) begin
      m_out = in;
    end else if (call) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(ra);
      end else if (ERR_EN) begin
        m_err = 1'b1;
      end else begin
        void'(m_q.pop_front());
        m_q.push_back(ra);
      end
      m_out = in;
    end else if (ret) begin
      if (m_q.size() > 0) m_out = m_q.pop_back();
      else if (ERR_EN) m_err = 1'b1;
    end else if (inc) begin
      m_out = ra;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out",   32'(out),   32'(m_out));
      check("depth", 32'(depth), 32'(m_q.size()));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full",  32'(full),  32'(m_q.size() == DEPTH));
      check("err",   32'(err),   32'(m_err));
    end
  end

  task automatic step(input logic r, input logic l, input logic c, input logic rt,
                      input logic i, input logic [WIDTH-1:0] d);
    reset = r; load = l; call = c; ret = rt; inc = i; in = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0; in = '0;
    m_out = '0; m_err = 1'b0;
    chk_en = 1'b1;

    // 1: reset beats load
    step(1, 1, 0, 0, 0, 16'h1234);
    check("t1_out", 32'(out), 32'h0);
    check("t1_depth", 32'(depth), 32'h0);
    check("t1_empty", 32'(empty), 32'h1);
    check("t1_err", 32'(err), 32'h0);

    // 2: increment and wrap
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 1, 16'h0);
      check("t2_inc", 32'(out), 32'(k));
    end
    step(0, 1, 0, 0, 0, 16'hFFFF);
    step(0, 0, 0, 0, 1, 16'h0);
    check("t2_wrap", 32'(out), 32'h0);

    // 3: call / return
    step(0, 1, 0, 0, 0, 16'h0010);
    step(0, 0, 1, 0, 0, 16'h0200);
    check("t3_call_out", 32'(out), 32'h0200);
    check("t3_call_depth", 32'(depth), 32'h1);
    step(0, 0, 0, 1, 0, 16'h0);
    check("t3_ret_out", 32'(out), 32'h0011);
    check("t3_ret_empty", 32'(empty), 32'h1);

    // 4: load wins over call and inc
    step(0, 1, 1, 0, 1, 16'h0040);
    check("t4_out", 32'(out), 32'h0040);
    check("t4_depth", 32'(depth), 32'h0);

    // 5: overflow then unwind
    step(1, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k <= DEPTH; k++) step(0, 0, 1, 0, 0, 16'h0100);
    check("t5_full", 32'(full), 32'h1);
    check("t5_err", 32'(err), 32'(ERR_EN));
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 0, 1, 0, 16'h0);
      if (ERR_EN && k == DEPTH - 1) check("t5_ret_last", 32'(out), 32'h0001);
      else check("t5_ret", 32'(out), 32'h0101);
    end
    check("t5_empty", 32'(empty), 32'h1);

    // 6: underflow at reset state
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 1, 0, 16'h0);
    check("t6_out", 32'(out), 32'h0);
    check("t6_depth", 32'(depth), 32'h0);
    check("t6_err", 32'(err), 32'(ERR_EN));
    step(1, 0, 0, 0, 0, 16'h0);
    check("t6_err_clr", 32'(err), 32'h0);

    // Randomized command mix, biased toward call/ret so the stack fills and drains.
    for (int n = 0; n < 3000; n++) begin
      logic r, l, c, rt, i;
      logic [WIDTH-1:0] d;
      int sel;
      sel = $urandom_range(0, 99);
      r  = ($urandom_range(0, 199) == 0);
      l  = (sel < 8);
      c  = (sel >= 5 && sel < 45) || ($urandom_range(0, 9) == 0);
      rt = (sel >= 40 && sel < 80) || ($urandom_range(0, 9) == 0);
      i  = (sel >= 75) || ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : WIDTH'($urandom);
      step(r, l, c, rt, i, d);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
